// File: rtl/reg_file_pkg.sv
// Shared types for the register file and its status-flag register.
package reg_file_pkg;

  typedef enum logic {
    SC_FROM_OUTBIT = 1'b0,
    SC_FROM_PARITY = 1'b1
  } sc_sel_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_flag_reg.sv
// Status flags for the ALU: SC (shift/carry-in), ZeroF and ParityF.
// SC clear beats SC write; all three flags reset asynchronously.
module flag_reg
  import reg_file_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_flag_we,
  input  logic    i_zero,
  input  logic    i_parity,
  input  logic    i_out_bit,
  input  logic    i_sc_we,
  input  sc_sel_t i_sc_sel,
  input  logic    i_sc_clr,
  output logic    o_sc,
  output logic    o_zero_f,
  output logic    o_parity_f
);

  logic r_sc;
  logic r_zero_f;
  logic r_parity_f;
  logic w_sc_src;

  assign w_sc_src = (i_sc_sel == SC_FROM_PARITY) ? i_parity : i_out_bit;

  // NOTE: state is updated with <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sc <= 1'b0;
    end else if (i_sc_clr) begin
      r_sc <= 1'b0;
    end else if (i_sc_we) begin
      r_sc <= w_sc_src;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zero_f   <= 1'b0;
      r_parity_f <= 1'b0;
    end else if (i_flag_we) begin
      r_zero_f   <= i_zero;
      r_parity_f <= i_parity;
    end
  end

  assign o_sc       = r_sc;
  assign o_zero_f   = r_zero_f;
  assign o_parity_f = r_parity_f;

`ifndef SYNTHESIS
  // OutBit is only meaningful for GETB; an X here means the controller selected it at the wrong time.
  a_out_bit_known : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (i_sc_we && !i_sc_clr && (i_sc_sel == SC_FROM_OUTBIT)) |-> !$isunknown(i_out_bit)
  );
`endif

endmodule : flag_reg

// File: rtl/reg_file.sv
// Architectural register file feeding the ALU, plus its status flags.
// Optional macro REG_FILE_BYPASS_EN forwards DataIn to a read port that matches Waddr.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         WriteEn,
  input  logic [A-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic         FlagWe,
  input  logic         ZeroIn,
  input  logic         ParityIn,
  input  logic         OutBitIn,
  input  logic         ScWe,
  input  sc_sel_t      ScSel,
  input  logic         ScClr,
  output logic         SC_out,
  output logic         ZeroF,
  output logic         ParityF
);

  localparam int NUM_REGS = 2 ** A;

  logic [W-1:0] r_mem [NUM_REGS];

  // NOTE: the array is built from resettable flops (not a RAM macro) because every register must clear on reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (WriteEn) begin
      r_mem[Waddr] <= DataIn;
    end
  end

  // NOTE: outputs get a default before any conditional override so no latch can be inferred.
  always_comb begin
    DataOutA = r_mem[RaddrA];
    DataOutB = r_mem[RaddrB];
`ifdef REG_FILE_BYPASS_EN
    if (WriteEn && (Waddr == RaddrA)) DataOutA = DataIn;
    if (WriteEn && (Waddr == RaddrB)) DataOutB = DataIn;
`endif
  end

  flag_reg u_flag_reg (
    .i_clk      (Clk),
    .i_rst_n    (Reset),
    .i_flag_we  (FlagWe),
    .i_zero     (ZeroIn),
    .i_parity   (ParityIn),
    .i_out_bit  (OutBitIn),
    .i_sc_we    (ScWe),
    .i_sc_sel   (ScSel),
    .i_sc_clr   (ScClr),
    .o_sc       (SC_out),
    .o_zero_f   (ZeroF),
    .o_parity_f (ParityF)
  );

endmodule : reg_file

// File: doc/reg_file.md
# reg_file

Architectural register file and status-flag register for the basic processor datapath. Sits directly upstream of the combinational ALU and supplies both operands (InputA, InputB) and the shift/carry-in bit (SC_in). It also captures the ALU's result (Out) and status outputs (Zero, Parity, OutBit) on the following clock edge. Reads are combinational; all state updates are synchronous to Clk.

## Interface
Parameters:
- W, 8, data width; must match the ALU's W.
- A, 3, address width; the block holds 2^A registers.

Ports:
- Clk  in  1  system clock; all writes occur on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- RaddrA  in  A  read address, port A (feeds ALU InputA).
- RaddrB  in  A  read address, port B (feeds ALU InputB).
- DataOutA  out  W  register[RaddrA].
- DataOutB  out  W  register[RaddrB].
- WriteEn  in  1  write strobe for the data array.
- Waddr  in  A  write address.
- DataIn  in  W  write data (ALU Out or load data).
- FlagWe  in  1  capture ZeroIn/ParityIn into the flag register.
- ZeroIn  in  1  ALU Zero.
- ParityIn  in  1  ALU Parity.
- OutBitIn  in  1  ALU OutBit.
- ScWe  in  1  update the SC flag.
- ScSel  in  1  SC source: 0 = OutBitIn, 1 = ParityIn.
- ScClr  in  1  synchronous clear of SC.
- SC_out  out  1  registered SC flag (drives ALU SC_in).
- ZeroF  out  1  registered zero flag.
- ParityF  out  1  registered parity flag.

## Operation
- Reset low, asynchronously:
  - All 2^A registers go to 0.
  - SC_out, ZeroF and ParityF go to 0.
  - State holds while Reset is low; any write in progress that cycle is discarded.
- Reads are purely combinational: DataOutA = reg[RaddrA], DataOutB = reg[RaddrB]. Both ports may address the same register.
- Data write: on the rising edge with WriteEn=1, reg[Waddr] <= DataIn. Every address 0..2^A-1 is writable; no register is hardwired.
- Flag write: on the rising edge with FlagWe=1, ZeroF <= ZeroIn and ParityF <= ParityIn. Otherwise both hold.
- SC update, in priority order:
  - ScClr=1 → SC <= 0.
  - else ScWe=1 → SC <= (ScSel ? ParityIn : OutBitIn).
  - else SC holds.
- OutBitIn is only valid for the ALU's GETB operation. The controller asserts ScWe with ScSel=0 only for GETB. With SVA enabled in simulation, the block flags an X on OutBitIn when it is selected.
- WriteEn, FlagWe and ScWe are independent; any combination may be asserted in the same cycle.

## Timing
- Read latency is 0 cycles (combinational). Write-to-read latency is 1 cycle: the new value is visible on DataOutA/DataOutB immediately after the rising edge.
- Same-cycle write and read of the same address, without bypass: the read returns the old value until the edge. With bypass, see Configuration.
- Flags and SC change only on rising edges. There is no combinational path from ZeroIn, ParityIn or OutBitIn to any output.
- Reset deassertion is synchronized externally; the first write is honoured on the first rising edge after Reset goes high.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - If WriteEn=1 and Waddr==RaddrA, DataOutA = DataIn combinationally. The same rule applies independently to port B.
  - Flags are not bypassed.
- REG_FILE_BYPASS_EN undefined: reads always return stored contents.
- The controller must not create a combinational loop DataIn → ALU → DataIn when bypass is enabled. The ALU's DataIn is registered elsewhere, or bypass is used only for load data.

## Structure
- Package Definitions:
  - Add typedef enum logic {SC_FROM_OUTBIT=0, SC_FROM_PARITY=1} sc_sel_t and use it for ScSel.
  - Add localparam NUM_REGS = 2**A helper only if A is fixed globally; otherwise keep it local.
- Sub-module flag_reg holds SC, ZeroF and ParityF, with the ScClr > ScWe priority and its own async active-low reset.
- The data array and read/bypass muxes stay in reg_file.

## Test plan
- Async reset: write 8'hA5 to r3, then pull Reset low mid-cycle. Required: DataOutA (RaddrA=3) reads 8'h00 immediately, and SC_out, ZeroF, ParityF are all 0.
- Write/read: write 8'h3C to r5 and 8'hFF to r7 on consecutive edges, then RaddrA=5, RaddrB=7. Required: DataOutA=8'h3C, DataOutB=8'hFF; the same address on both ports gives identical data.
- Write-then-read same cycle (WriteEn=1, Waddr=RaddrA=2, DataIn=8'h11, old value 8'h00):
  - Bypass off: DataOutA=8'h00 before the edge and 8'h11 after.
  - Bypass on: 8'h11 before the edge.
- SC priority:
  - ScWe=1, ScSel=0, OutBitIn=1, ScClr=1 → SC_out=0 after the edge.
  - Next cycle ScClr=0 → SC_out=1.
  - ScSel=1, ParityIn=0 → SC_out=0.
- Flags: FlagWe=1, ZeroIn=1, ParityIn=1 → ZeroF=1, ParityF=1 after the edge. Then FlagWe=0 with inputs toggled → both hold at 1.
- Simultaneous: WriteEn, FlagWe and ScWe all set in one cycle (r0 <= 8'h80, ZeroIn=0, ParityIn=1, ScSel=1). Required after the edge: r0=8'h80, ZeroF=0, ParityF=1, SC_out=1.
